// File: rtl/vector_acc_ctrl.sv
// Sequencer for the unsigned vector accumulator: frames samples into vectors,
// issues new_acc per integration and gates the accumulator dump stream.
module vector_acc_ctrl #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 64,
    parameter int VECTOR_LEN = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  acc_len_valid,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic                  sync_in,
    output logic [DIN_WIDTH-1:0]  acc_din,
    output logic                  acc_din_valid,
    output logic                  acc_new,
    input  logic [DOUT_WIDTH-1:0] acc_dout,
    input  logic                  acc_dout_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic [LEN_WIDTH-1:0]  integ_count,
    output logic                  busy,
    output logic                  sync_err
);

    localparam int CNT_W = $clog2(VECTOR_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  acc_len_sh_q, acc_len_sh_d;
    logic [LEN_WIDTH-1:0]  acc_len_r_q, acc_len_r_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [LEN_WIDTH-1:0]  vec_cnt_q, vec_cnt_d;
    logic                  first_dump_q, first_dump_d;
    logic                  skip_q, skip_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [LEN_WIDTH-1:0]  integ_count_q, integ_count_d;
    logic                  sync_err_q, sync_err_d;
    logic [DIN_WIDTH-1:0]  acc_din_q, acc_din_d;
    logic                  acc_din_valid_q, acc_din_valid_d;
    logic                  acc_new_q, acc_new_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_last_q, dout_last_d;

    logic boundary;
    logic first_set;
    logic first_clr;
    logic dump_skip;

    always_comb begin
        state_d         = state_q;
        acc_len_sh_d    = acc_len_sh_q;
        acc_len_r_d     = acc_len_r_q;
        sample_cnt_d    = sample_cnt_q;
        vec_cnt_d       = vec_cnt_q;
        sync_err_d      = sync_err_q;
        acc_din_d       = acc_din_q;
        acc_din_valid_d = 1'b0;
        acc_new_d       = 1'b0;
        first_set       = 1'b0;
        boundary        = (sample_cnt_q == LAST_IDX) &&
                          (vec_cnt_q == acc_len_r_q - LEN_WIDTH'(1));

        if (acc_len_valid) begin
            acc_len_sh_d = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (din_valid && sync_in) begin
                    state_d         = RUN;
                    acc_din_d       = din;
                    acc_din_valid_d = 1'b1;
                    acc_new_d       = 1'b1;
                    sample_cnt_d    = CNT_W'(1);
                    vec_cnt_d       = '0;
                    acc_len_r_d     = acc_len_sh_q;
                    first_set       = 1'b1;
                end
            end
            RUN: begin
                if (din_valid) begin
                    acc_din_d       = din;
                    acc_din_valid_d = 1'b1;
                    if (sync_in && (sample_cnt_q != '0)) begin
                        // Misaligned sync: restart framing on this sample
                        sync_err_d   = 1'b1;
                        acc_new_d    = 1'b1;
                        sample_cnt_d = CNT_W'(1);
                        vec_cnt_d    = '0;
                        first_set    = 1'b1;
                    end else begin
                        acc_new_d    = (sample_cnt_q == '0) && (vec_cnt_q == '0);
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                        if (boundary) begin
                            vec_cnt_d   = '0;
                            acc_len_r_d = acc_len_sh_q;
                            if (!enable) begin
                                state_d = IDLE;
                            end
                        end else if (sample_cnt_q == LAST_IDX) begin
                            vec_cnt_d = vec_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Suppression is decided on the first beat and held for the whole dump,
        // so a first_dump raised mid-dump only affects the following dump.
        dump_skip     = (out_cnt_q == '0) ? first_dump_q : skip_q;
        skip_d        = skip_q;
        out_cnt_d     = out_cnt_q;
        first_clr     = 1'b0;
        dout_d        = acc_dout;
        dout_valid_d  = acc_dout_valid && !dump_skip;
        dout_last_d   = dout_valid_d && (out_cnt_q == LAST_IDX);
        integ_count_d = integ_count_q;
        if (dout_last_d) begin
            integ_count_d = integ_count_q + LEN_WIDTH'(1);
        end
        if (acc_dout_valid) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
            skip_d    = dump_skip;
            if ((out_cnt_q == LAST_IDX) && dump_skip) begin
                first_clr = 1'b1;
            end
        end

        first_dump_d = first_dump_q;
        if (first_set) begin
            first_dump_d = 1'b1;
        end else if (first_clr) begin
            first_dump_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            acc_len_sh_q    <= LEN_WIDTH'(1);
            acc_len_r_q     <= LEN_WIDTH'(1);
            sample_cnt_q    <= '0;
            vec_cnt_q       <= '0;
            first_dump_q    <= 1'b1;
            skip_q          <= 1'b0;
            out_cnt_q       <= '0;
            integ_count_q   <= '0;
            sync_err_q      <= 1'b0;
            acc_din_q       <= '0;
            acc_din_valid_q <= 1'b0;
            acc_new_q       <= 1'b0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            dout_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_len_sh_q    <= acc_len_sh_d;
            acc_len_r_q     <= acc_len_r_d;
            sample_cnt_q    <= sample_cnt_d;
            vec_cnt_q       <= vec_cnt_d;
            first_dump_q    <= first_dump_d;
            skip_q          <= skip_d;
            out_cnt_q       <= out_cnt_d;
            integ_count_q   <= integ_count_d;
            sync_err_q      <= sync_err_d;
            acc_din_q       <= acc_din_d;
            acc_din_valid_q <= acc_din_valid_d;
            acc_new_q       <= acc_new_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            dout_last_q     <= dout_last_d;
        end
    end

    assign acc_din       = acc_din_q;
    assign acc_din_valid = acc_din_valid_q;
    assign acc_new       = acc_new_q;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign dout_last     = dout_last_q;
    assign integ_count   = integ_count_q;
    assign busy          = (state_q == RUN);
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_vector_acc_ctrl.sv
// Randomized bench for vector_acc_ctrl with a behavioural accumulator and
// an integration-level reference model.
module tb_vector_acc_ctrl;

    localparam int VL = 4;
    localparam int DW = 32;
    localparam int OW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [LW-1:0] acc_len;
    logic          acc_len_valid;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          sync_in;
    logic [DW-1:0] acc_din;
    logic          acc_din_valid;
    logic          acc_new;
    logic [OW-1:0] acc_dout;
    logic          acc_dout_valid;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic [LW-1:0] integ_count;
    logic          busy;
    logic          sync_err;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] mon_q[$];
    logic          last_q[$];
    logic [DW-1:0] samp[64];

    vector_acc_ctrl #(
        .DIN_WIDTH (DW),
        .DOUT_WIDTH(OW),
        .VECTOR_LEN(VL),
        .LEN_WIDTH (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .acc_len       (acc_len),
        .acc_len_valid (acc_len_valid),
        .din           (din),
        .din_valid     (din_valid),
        .sync_in       (sync_in),
        .acc_din       (acc_din),
        .acc_din_valid (acc_din_valid),
        .acc_new       (acc_new),
        .acc_dout      (acc_dout),
        .acc_dout_valid(acc_dout_valid),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_last     (dout_last),
        .integ_count   (integ_count),
        .busy          (busy),
        .sync_err      (sync_err)
    );

    always #5 clk = ~clk;

    // Accumulator stand-in: on new_acc it dumps the previous sums, one beat per cycle
    logic [OW-1:0] sums[VL];
    logic [OW-1:0] dbuf[VL];
    int unsigned   aidx;
    int unsigned   dpos;
    logic          dactive;

    always @(negedge clk) begin
        if (rst) begin
            dactive        <= 1'b0;
            acc_dout       <= '0;
            acc_dout_valid <= 1'b0;
            aidx           <= 0;
            dpos           <= 0;
            for (int i = 0; i < VL; i++) sums[i] <= '0;
        end else begin
            if (dactive) begin
                acc_dout       <= dbuf[dpos];
                acc_dout_valid <= 1'b1;
                dpos           <= dpos + 1;
                if (dpos == VL - 1) dactive <= 1'b0;
            end else begin
                acc_dout_valid <= 1'b0;
            end
            if (acc_din_valid) begin
                if (acc_new) begin
                    for (int i = 0; i < VL; i++) begin
                        dbuf[i] <= sums[i];
                        sums[i] <= (i == 0) ? OW'(acc_din) : '0;
                    end
                    aidx    <= 1;
                    dpos    <= 0;
                    dactive <= 1'b1;
                end else begin
                    sums[aidx] <= sums[aidx] + OW'(acc_din);
                    aidx       <= (aidx + 1) % VL;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            mon_q.push_back(dout);
            last_q.push_back(dout_last);
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic v, input logic s);
        din = d; din_valid = v; sync_in = s;
        @(posedge clk); #1;
        din_valid = 1'b0; sync_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; acc_len_valid = 1'b0; din_valid = 1'b0; sync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        mon_q.delete(); last_q.delete();
    endtask

    task automatic start(input logic [LW-1:0] len);
        acc_len = len; acc_len_valid = 1'b1;
        @(posedge clk); #1;
        acc_len_valid = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        mon_q.delete(); last_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        do_reset();
        got = {acc_din_valid, acc_new, dout_valid, dout_last, busy, sync_err, |integ_count, |acc_din};
        checks++; if (got !== 8'h00) begin errors++; $display("FAIL reset_flags got %b exp 00000000", got); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %0h exp 0", dout); end
    endtask

    task automatic test_presync();
        logic [DW-1:0] d;
        do_reset();
        start(2);
        for (int k = 0; k < 3; k++) begin
            send($urandom, 1'b1, 1'b0);
            checks++; if (acc_din_valid !== 1'b0) begin errors++; $display("FAIL presync_valid k=%0d got %b exp 0", k, acc_din_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL presync_busy k=%0d got %b exp 0", k, busy); end
        end
        d = $urandom;
        send(d, 1'b1, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sync_busy got %b exp 1", busy); end
        checks++; if ({acc_din_valid, acc_new} !== 2'b11) begin errors++; $display("FAIL sync_first got %b exp 11", {acc_din_valid, acc_new}); end
        checks++; if (acc_din !== d) begin errors++; $display("FAIL sync_din got %0h exp %0h", acc_din, d); end
    endtask

    task automatic test_integration();
        localparam int L = 2;
        localparam int M = 3;
        logic [OW-1:0] e;
        logic          s;
        do_reset();
        start(L);
        for (int k = 0; k < VL * L * (M + 1); k++) begin
            if ($urandom_range(3) == 0) send('0, 1'b0, 1'b0);
            samp[k] = $urandom;
            s = (k % VL == 0) && (k == 0 || $urandom_range(1) == 1);
            send(samp[k], 1'b1, s);
            checks++; if (acc_din_valid !== 1'b1 || acc_din !== samp[k]) begin errors++; $display("FAIL int_fwd k=%0d got %b/%0h exp 1/%0h", k, acc_din_valid, acc_din, samp[k]); end
            checks++; if (acc_new !== (k % (VL * L) == 0)) begin errors++; $display("FAIL int_new k=%0d got %b exp %b", k, acc_new, (k % (VL * L) == 0)); end
        end
        for (int c = 0; c < 40 && mon_q.size() < M * VL; c++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (mon_q.size() != M * VL) begin errors++; $display("FAIL int_beats got %0d exp %0d", mon_q.size(), M * VL); end
        for (int j = 0; j < M; j++) begin
            for (int p = 0; p < VL; p++) begin
                e = '0;
                for (int v = 0; v < L; v++) e += OW'(samp[j * VL * L + v * VL + p]);
                if (j * VL + p < mon_q.size()) begin
                    checks++; if (mon_q[j * VL + p] !== e) begin errors++; $display("FAIL int_dout j=%0d p=%0d got %0h exp %0h", j, p, mon_q[j * VL + p], e); end
                    checks++; if (last_q[j * VL + p] !== (p == VL - 1)) begin errors++; $display("FAIL int_last j=%0d p=%0d got %b exp %b", j, p, last_q[j * VL + p], (p == VL - 1)); end
                end
            end
        end
        checks++; if (integ_count !== LW'(M)) begin errors++; $display("FAIL int_count got %0d exp %0d", integ_count, M); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL int_syncerr got %b exp 0", sync_err); end
    endtask

    task automatic test_sync_err();
        logic [OW-1:0] e;
        logic          exp_new;
        do_reset();
        start(2);
        for (int k = 0; k < 18; k++) begin
            samp[k] = $urandom;
            if (k < 6) begin
                send(samp[k], 1'b1, k % VL == 0);
                exp_new = (k == 0);
            end else begin
                send(samp[k], 1'b1, (k - 6) % VL == 0);
                exp_new = ((k - 6) % (2 * VL) == 0);
            end
            checks++; if (acc_new !== exp_new) begin errors++; $display("FAIL serr_new k=%0d got %b exp %b", k, acc_new, exp_new); end
            if (k == 6) begin
                checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL serr_flag got %b exp 1", sync_err); end
            end
        end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL serr_sticky got %b exp 1", sync_err); end
        checks++; if (mon_q.size() != VL) begin errors++; $display("FAIL serr_beats got %0d exp %0d", mon_q.size(), VL); end
        for (int p = 0; p < VL && p < mon_q.size(); p++) begin
            e = OW'(samp[6 + p]) + OW'(samp[10 + p]);
            checks++; if (mon_q[p] !== e) begin errors++; $display("FAIL serr_dout p=%0d got %0h exp %0h", p, mon_q[p], e); end
        end
    endtask

    task automatic test_len_change();
        int   sh, cur, left;
        logic exp_new;
        do_reset();
        start(2);
        sh = 2; cur = 2; left = 0;
        for (int k = 0; k < 44; k++) begin
            exp_new = (left == 0);
            if (left == 0) left = cur * VL;
            if (k == 2)  begin acc_len = 3; acc_len_valid = 1'b1; end
            if (k == 19) begin acc_len = 0; acc_len_valid = 1'b1; end
            send($urandom, 1'b1, k % VL == 0);
            left--;
            if (left == 0) cur = sh;
            if (acc_len_valid) sh = (acc_len == 0) ? 1 : int'(acc_len);
            acc_len_valid = 1'b0;
            checks++; if (acc_new !== exp_new || acc_din_valid !== 1'b1) begin errors++; $display("FAIL len_new k=%0d got %b/%b exp %b/1", k, acc_new, acc_din_valid, exp_new); end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        start(2);
        for (int k = 0; k < 12; k++) begin
            send($urandom, 1'b1, k % VL == 0);
            if (k == 2) enable = 1'b0;
            checks++; if (acc_din_valid !== (k < 8) || acc_new !== (k == 0)) begin errors++; $display("FAIL drop_fwd k=%0d got %b/%b exp %b/%b", k, acc_din_valid, acc_new, (k < 8), (k == 0)); end
            checks++; if (busy !== (k < 7)) begin errors++; $display("FAIL drop_busy k=%0d got %b exp %b", k, busy, (k < 7)); end
        end
        enable = 1'b1;
        @(posedge clk); #1;
        send($urandom, 1'b1, 1'b0);
        checks++; if (acc_din_valid !== 1'b0) begin errors++; $display("FAIL reen_drop got %b exp 0", acc_din_valid); end
        send($urandom, 1'b1, 1'b1);
        checks++; if ({acc_new, busy} !== 2'b11) begin errors++; $display("FAIL reen_start got %b exp 11", {acc_new, busy}); end
    endtask

    task automatic test_rst_dump();
        logic seen;
        do_reset();
        start(1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            send($urandom, 1'b1, k % VL == 0);
            if (dout_valid === 1'b1 && integ_count != 0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_wait got %b exp 1", seen); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({dout_valid, busy, acc_din_valid} !== 3'b000) begin errors++; $display("FAIL rst_outs got %b exp 000", {dout_valid, busy, acc_din_valid}); end
        checks++; if (integ_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", integ_count); end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; acc_len = '0; acc_len_valid = 1'b0;
        din = '0; din_valid = 1'b0; sync_in = 1'b0;
        test_reset();
        test_presync();
        test_integration();
        test_sync_err();
        test_len_change();
        test_enable_drop();
        test_rst_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
